// File: rtl/vx_split_join_ctrl.sv
// rtl/vx_split_join_ctrl.sv - per-warp SPLIT/JOIN divergence controller ahead of the IPDOM stack
//
// Turns SPLIT/JOIN requests from the execute stage into IPDOM stack push/pop
// strobes and returns the resulting thread mask / PC redirect to the warp
// scheduler through a registered valid/ready response.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   req_valid/ready     request handshake (fire = req_valid & req_ready)
//   req_is_join         0 = SPLIT, 1 = JOIN
//   req_tmask           current active thread mask
//   req_taken           per-thread branch predicate (SPLIT)
//   req_next_pc         else-path PC (SPLIT)
//   stk_push, stk_pop   stack strobes, only asserted in a fire cycle
//   stk_q1, stk_q2      restore entry and else entry pushed on a divergent SPLIT
//   stk_d               stack top {fallthru, tmask, pc}, read combinationally
//   stk_empty/full      stack status
//   rsp_valid/ready     response handshake
//   rsp_tmask, rsp_pc   new thread mask and redirect target
//   rsp_pc_en           redirect PC to rsp_pc
//   rsp_diverged        SPLIT pushed an entry
//   rsp_err             JOIN on an empty stack
module vx_split_join_ctrl #(
    parameter  int NUM_THREADS = 4,
    parameter  int PC_BITS     = 32,
    localparam int ENTRYW      = 1 + NUM_THREADS + PC_BITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_is_join,
    input  logic [NUM_THREADS-1:0] req_tmask,
    input  logic [NUM_THREADS-1:0] req_taken,
    input  logic [PC_BITS-1:0]     req_next_pc,
    output logic                   stk_push,
    output logic                   stk_pop,
    output logic [ENTRYW-1:0]      stk_q1,
    output logic [ENTRYW-1:0]      stk_q2,
    input  logic [ENTRYW-1:0]      stk_d,
    input  logic                   stk_empty,
    input  logic                   stk_full,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [NUM_THREADS-1:0] rsp_tmask,
    output logic [PC_BITS-1:0]     rsp_pc,
    output logic                   rsp_pc_en,
    output logic                   rsp_diverged,
    output logic                   rsp_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RSP  = 1'b1
    } state_t;

    state_t state;

    // SPLIT mask evaluation
    logic [NUM_THREADS-1:0] taken_m;
    logic [NUM_THREADS-1:0] else_m;
    logic                   divergent;
    logic                   stall;
    logic                   fire;

    // Stack top fields
    logic                   d_fallthru;
    logic [NUM_THREADS-1:0] d_tmask;
    logic [PC_BITS-1:0]     d_pc;

    // Response to be loaded on a fire
    logic [NUM_THREADS-1:0] nxt_tmask;
    logic [PC_BITS-1:0]     nxt_pc;
    logic                   nxt_pc_en;
    logic                   nxt_diverged;
    logic                   nxt_err;

    assign taken_m   = req_tmask & req_taken;
    assign else_m    = req_tmask & ~req_taken;
    assign divergent = (taken_m != '0) && (else_m != '0);

    // Only a divergent SPLIT needs stack space; uniform SPLITs and JOINs
    // proceed even when the stack is full.
    assign stall = !req_is_join && divergent && stk_full;

    // The output slot is free when nothing is held or the held response
    // leaves this cycle, which allows one request per cycle back-to-back.
    assign req_ready = !reset && (!rsp_valid || rsp_ready) && !stall;
    assign fire      = req_valid && req_ready;

    assign stk_push = fire && !req_is_join && divergent;
    assign stk_pop  = fire && req_is_join && !stk_empty;

    assign stk_q1 = {1'b1, req_tmask, {PC_BITS{1'b0}}};
    assign stk_q2 = {1'b0, else_m, req_next_pc};

    assign d_fallthru = stk_d[ENTRYW-1];
    assign d_tmask    = stk_d[PC_BITS +: NUM_THREADS];
    assign d_pc       = stk_d[PC_BITS-1:0];

    always_comb begin
        nxt_tmask    = req_tmask;
        nxt_pc       = '0;
        nxt_pc_en    = 1'b0;
        nxt_diverged = 1'b0;
        nxt_err      = 1'b0;
        if (!req_is_join) begin
            if (divergent) begin
                // Taken threads run first; the else path waits on the stack.
                nxt_tmask    = taken_m;
                nxt_diverged = 1'b1;
            end
        end else if (stk_empty) begin
            nxt_err = 1'b1;
        end else begin
            // stk_d is the top before this cycle's pop takes effect.
            nxt_tmask = d_tmask;
            if (!d_fallthru) begin
                nxt_pc    = d_pc;
                nxt_pc_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            rsp_valid    <= 1'b0;
            rsp_tmask    <= '0;
            rsp_pc       <= '0;
            rsp_pc_en    <= 1'b0;
            rsp_diverged <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fire) begin
                        state        <= ST_RSP;
                        rsp_valid    <= 1'b1;
                        rsp_tmask    <= nxt_tmask;
                        rsp_pc       <= nxt_pc;
                        rsp_pc_en    <= nxt_pc_en;
                        rsp_diverged <= nxt_diverged;
                        rsp_err      <= nxt_err;
                    end
                end
                ST_RSP: begin
                    // fire implies rsp_ready here, so the held response is
                    // only replaced once the scheduler has taken it.
                    if (fire) begin
                        rsp_tmask    <= nxt_tmask;
                        rsp_pc       <= nxt_pc;
                        rsp_pc_en    <= nxt_pc_en;
                        rsp_diverged <= nxt_diverged;
                        rsp_err      <= nxt_err;
                    end else if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
